// File: rtl/regfile_sb.sv
// Multi-read-port register file with a busy scoreboard and a handshaked dump engine.
// Optional write-first read bypass is enabled by defining REGFILE_SB_BYPASS_EN.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRP  = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                dump_start,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [XLEN-1:0]     dump_data,
  output logic                dump_done
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] sb_q, sb_d;
  logic            wr_act, iss_act;

  assign wr_act  = wr_en && (wr_addr != '0);
  assign iss_act = iss_en && (iss_addr != '0);

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_act) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Set is applied after clear so a same-cycle new producer wins.
  always_comb begin
    sb_d = sb_q;
    if (wr_act)  sb_d[wr_addr]  = 1'b0;
    if (iss_act) sb_d[iss_addr] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sb_q <= '0;
    else         sb_q <= sb_d;
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[k*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
    logic hit;
    assign hit = wr_act && (addr == wr_addr);
    assign rd_data[k*XLEN +: XLEN] = hit ? wr_data : regs_q[addr];
    assign rd_busy[k] = hit ? (iss_act && (iss_addr == wr_addr)) : sb_q[addr];
`else
    assign rd_data[k*XLEN +: XLEN] = regs_q[addr];
    assign rd_busy[k] = sb_q[addr];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (dump_start) state_d = StSend;
      end
      StSend: begin
        if (dump_ready) begin
          if (cnt_q == AW'(NREG - 1)) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Dump data is read from stored state, never bypassed, and tracks updates while held.
  assign dump_valid = (state_q == StSend);
  assign dump_idx   = cnt_q;
  assign dump_data  = dump_valid ? regs_q[cnt_q] : '0;
  assign dump_done  = done_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port integer register file with a per-register busy scoreboard and a handshaked register-dump engine. It sits in the decode stage of the 5-stage RISC-V pipeline:
- Read ports feed operand fetch.
- Issue marks destination registers pending.
- Writeback clears pending and stores results.
- The dump engine streams the whole architectural state to the debug/trace path without stalling the core.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of registers (power of two, ≥ 2); AW = $clog2(NREG)
- NRP, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- rd_addr  in  NRP*AW  packed read addresses; port k at [k*AW +: AW]
- rd_data  out  NRP*XLEN  packed read data; port k at [k*XLEN +: XLEN]
- rd_busy  out  NRP  per-port: addressed register has an outstanding producer
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register index
- wr_data  in  XLEN  writeback data
- iss_en  in  1  issue strobe: mark iss_addr busy
- iss_addr  in  AW  destination of issuing instruction
- dump_start  in  1  request a full register dump (single-cycle pulse)
- dump_valid  out  1  dump_idx/dump_data valid
- dump_ready  in  1  consumer accepts current dump beat
- dump_idx  out  AW  index of current dump beat
- dump_data  out  XLEN  contents of register dump_idx
- dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Register 0 is hardwired to zero:
  - Writes to index 0 are discarded.
  - Issue to index 0 is discarded; register 0 is never busy.
  - Reads of index 0 return 0.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data.
- Scoreboard sb[NREG], one bit per register:
  - iss_en with iss_addr≠0 sets sb[iss_addr].
  - wr_en with wr_addr≠0 clears sb[wr_addr].
  - Same address, same cycle: the set wins (a new producer supersedes), so sb=1 afterwards.
  - Issue to an already-busy register leaves it busy.
- Reads are combinational and independent per port; any number of ports may address the same register.
- rd_busy[k] = sb[rd_addr_k], except as modified by the bypass (see Configuration).
- Dump FSM, states IDLE and SEND:
  - IDLE: dump_valid=0 and idx counter=0. dump_start=1 → SEND.
  - SEND: dump_valid=1, dump_idx=counter, dump_data=reg[counter] as stored (register 0 reads 0; no bypass).
  - SEND, dump_ready=1 and counter<NREG-1: counter+1.
  - SEND, dump_ready=1 and counter=NREG-1: → IDLE, counter←0, dump_done=1 for the next cycle.
  - dump_start while in SEND is ignored.
  - dump_data tracks register updates while a beat is held (it is not latched). dump_idx stays stable until the beat is accepted.
- The dump engine never blocks reads, writes or issue.

## Timing
- Reset (asynchronous, resetn=0):
  - All registers = 0, sb = 0, FSM = IDLE, counter = 0.
  - dump_valid=0, dump_done=0, dump_idx=0, dump_data=0.
  - rd_data and rd_busy reflect the cleared state (0).
- Reset asserted mid-dump aborts it immediately, with no dump_done.
- Write latency: data is visible to any read in the cycle after the write edge, or in the same cycle when bypass is enabled.
- Dump:
  - First beat is valid the cycle after dump_start.
  - With dump_ready held at 1, a full dump takes exactly NREG cycles of dump_valid.
  - dump_done rises in the cycle after the final handshake.
  - dump_start in the same cycle as dump_done is accepted, and a new dump begins.
- Back-pressure: dump_ready=0 holds the beat indefinitely.

## Configuration
- Macro REGFILE_SB_BYPASS_EN.
- Defined: write-first bypass on every read port when wr_en=1, wr_addr≠0 and rd_addr_k==wr_addr:
  - rd_data_k = wr_data.
  - rd_busy_k = 0, unless iss_en=1 and iss_addr==wr_addr in the same cycle, in which case rd_busy_k = 1.
- Undefined: reads return stored contents and the raw sb bit; a same-cycle write is seen one cycle later.
- Dump data is never bypassed in either build.

## Test plan
- Reset, then read all indices on every port → rd_data=0 and rd_busy=0 for every register. Write 0xDEADBEEF to x0 → read of x0 still returns 0.
- Write x5=0x12345678, then read x5 on all NRP ports simultaneously in the next cycle → all ports return 0x12345678.
- Issue x7; in the next cycle rd_busy=1 for x7. Write x7=0xA5A5A5A5 and read x7 in the same cycle:
  - BYPASS_EN: rd_data=0xA5A5A5A5, rd_busy=0.
  - Without: old value and busy=1.
  - The following cycle: 0xA5A5A5A5 and busy=0 in both builds.
- Same cycle: iss_en and wr_en both targeting x9 → sb[9]=1 after the edge and reg[9] holds the written data.
- Load x_i = i*0x11 for all i, pulse dump_start with dump_ready toggling 1,0,1,0… → NREG accepted beats with idx 0..31, data i*0x11 (x0=0); idx stable while ready=0; single dump_done pulse at the end.
- Assert resetn=0 during a dump at idx 10 → dump_valid drops immediately and no dump_done. After release, dump_start restarts the dump at idx 0.
